scene_sequencer: RTL

Frame-synchronous scene scheduler for the demoscene pixel pipeline. It owns the `background_state`, `solid_color` and motion counter that the pixel colour stage consumes, replacing their fixed values and the vsync-clocked counter. Scenes advance automatically after a programmable frame count, or on a user "next" request. Each scene change inserts a black blanking interval. All updates land one cycle after the detected frame start, so no change is visible mid-frame.

---
 rtl/scene_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/scene_sequencer.sv
// Frame-synchronous scene scheduler: steps background scenes on a frame budget or a user request,
// inserts black blanking between scenes and drives the per-frame motion counter.
module scene_sequencer #(
    parameter int unsigned NUM_SCENES   = 11,
    parameter int unsigned SCENE_FRAMES = 120,
    parameter int unsigned BLANK_FRAMES = 8,
    parameter int unsigned FRAME_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       pause,
    input  logic       next,
    output logic [7:0] background_state,
    output logic [5:0] solid_color,
    output logic [9:0] moving_counter,
    output logic       blank,
    output logic       frame_tick,
    output logic       scene_change
);

    typedef enum logic [1:0] {ST_RUN, ST_BLANK, ST_PAUSED} state_e;

    localparam logic [FRAME_W-1:0] SCENE_LAST = FRAME_W'(SCENE_FRAMES - 1);
    localparam logic [FRAME_W-1:0] BLANK_LAST = FRAME_W'((BLANK_FRAMES != 0) ? BLANK_FRAMES - 1 : 0);
    localparam logic [7:0]         SCENE_MAX  = 8'(NUM_SCENES - 1);
    localparam logic [5:0]         COLOR_RST  = 6'b110000;

    state_e             state_q;
    logic               vsync_q;
    logic               next_q;
    logic               frame_tick_q;
    logic               scene_change_q;
    logic               blank_q;
    logic               next_pending_q;
    logic [FRAME_W-1:0] frame_cnt_q;
    logic [7:0]         scene_q;
    logic [5:0]         color_q;
    logic [9:0]         motion_q;

    logic [7:0]         scene_d;
    logic [5:0]         color_d;
    logic               next_rise;

    assign next_rise = next & ~next_q;

    always_comb begin
        scene_d = scene_q + 8'd1;
        color_d = color_q;
        if (scene_q == SCENE_MAX) begin
            scene_d = '0;
            color_d = {color_q[3:0], color_q[5:4]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            vsync_q        <= 1'b0;
            next_q         <= 1'b0;
            frame_tick_q   <= 1'b0;
            scene_change_q <= 1'b0;
            blank_q        <= 1'b0;
            next_pending_q <= 1'b0;
            frame_cnt_q    <= '0;
            scene_q        <= '0;
            color_q        <= COLOR_RST;
            motion_q       <= '0;
        end else begin
            vsync_q        <= vsync;
            next_q         <= next;
            frame_tick_q   <= vsync & ~vsync_q;
            scene_change_q <= 1'b0;

            if (frame_tick_q) begin
                case (state_q)
                    ST_RUN: begin
                        if (pause) begin
                            state_q <= ST_PAUSED;
                        end else if (next_pending_q || frame_cnt_q == SCENE_LAST) begin
                            scene_q        <= scene_d;
                            color_q        <= color_d;
                            frame_cnt_q    <= '0;
                            motion_q       <= '0;
                            next_pending_q <= 1'b0;
                            scene_change_q <= 1'b1;
                            if (BLANK_FRAMES != 0) begin
                                state_q <= ST_BLANK;
                                blank_q <= 1'b1;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
                            motion_q    <= motion_q + 10'd1;
                        end
                    end
                    ST_BLANK: begin
                        if (frame_cnt_q == BLANK_LAST) begin
                            frame_cnt_q <= '0;
                            state_q     <= ST_RUN;
                            blank_q     <= 1'b0;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
                        end
                    end
                    ST_PAUSED: begin
                        if (!pause) begin
                            state_q <= ST_RUN;
                        end else if (next_pending_q) begin
                            scene_q        <= scene_d;
                            color_q        <= color_d;
                            frame_cnt_q    <= '0;
                            motion_q       <= '0;
                            next_pending_q <= 1'b0;
                            scene_change_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_RUN;
                endcase
            end

            // Placed after the tick handling so an edge on a tick cycle survives to the next tick.
            if (next_rise && state_q != ST_BLANK) begin
                next_pending_q <= 1'b1;
            end
        end
    end

    assign background_state = scene_q;
    assign solid_color      = color_q;
    assign moving_counter   = motion_q;
    assign blank            = blank_q;
    assign frame_tick       = frame_tick_q;
    assign scene_change     = scene_change_q;

endmodule
